// File: rtl/ula_pkg.sv
// Shared types for the ULA serial ALU: operation codes and controller states.
package ula_pkg;

  typedef enum logic [2:0] {
    FN_ADD   = 3'b000,
    FN_SUB   = 3'b001,
    FN_AND   = 3'b010,
    FN_OR    = 3'b011,
    FN_XNOR  = 3'b100,
    FN_NOTA  = 3'b101,
    FN_PASSA = 3'b110,
    FN_NOTB  = 3'b111
  } func_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic is_arith(input func_t f);
    return (f == FN_ADD) || (f == FN_SUB);
  endfunction

endpackage

// File: rtl/ula_slice.sv
// Combinational SLICE-bit ALU datapath reused every cycle by the serial controller.
// Carry outputs are forced low for logic funcs so the carry chain stays clean.
module ula_slice
  import ula_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  func_t            func,
  input  logic             cin,
  input  logic             eq_in,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             eq_out,
  output logic             ctop
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] bx;
  logic [SLICE-1:0] sum;
  logic             arith;

  always_comb begin
    bx   = (func == FN_SUB) ? ~b : b;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
    end
  end

  always_comb begin
    res = '0;
    case (func)
      FN_ADD, FN_SUB: res = sum;
      FN_AND:         res = a & b;
      FN_OR:          res = a | b;
      FN_XNOR:        res = ~(a ^ b);
      FN_NOTA:        res = ~a;
      FN_PASSA:       res = a;
      FN_NOTB:        res = ~b;
      default:        res = '0;
    endcase
  end

  assign arith  = is_arith(func);
  assign cout   = arith & c[SLICE];
  assign ctop   = arith & c[SLICE-1];
  assign eq_out = eq_in & (a == b);

endmodule

// File: rtl/ula_serial.sv
// Multi-cycle ALU: WIDTH-bit operands processed SLICE bits per cycle, LSB first.
// Optional signed-overflow flag built only when ULA_OVERFLOW_EN is defined.
module ula_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             eq,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_nx;
  func_t            func_q;
  logic             carry, eq_q, zero_q;
  logic             accept, last;
  logic [SLICE-1:0] s_res;
  logic             s_cout, s_eq, s_ctop;

  assign accept = in_valid && in_ready;
  assign last   = (state == ST_RUN) && (cnt == CW'(NSLICES - 1));

  ula_slice #(.SLICE(SLICE)) u_slice (
    .a      (a_q[cnt*SLICE +: SLICE]),
    .b      (b_q[cnt*SLICE +: SLICE]),
    .func   (func_q),
    .cin    (carry),
    .eq_in  (eq_q),
    .res    (s_res),
    .cout   (s_cout),
    .eq_out (s_eq),
    .ctop   (s_ctop)
  );

  always_comb begin
    r_nx = r_q;
    r_nx[cnt*SLICE +: SLICE] = s_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN:  if (last) state_nx = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand/result registers; result flags are frozen from the last slice onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      func_q <= FN_ADD;
      carry  <= 1'b0;
      eq_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_q    <= a;
      b_q    <= b;
      r_q    <= '0;
      func_q <= func_t'(func);
      carry  <= (func == FN_SUB);
      eq_q   <= 1'b1;
      zero_q <= 1'b0;
    end else if (state == ST_RUN) begin
      cnt   <= cnt + 1'b1;
      r_q   <= r_nx;
      carry <= s_cout;
      eq_q  <= s_eq;
      if (last) zero_q <= (r_nx == '0);
    end
  end

`ifdef ULA_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_q <= 1'b0;
    else if (accept) ovf_q <= 1'b0;
    else if (last)   ovf_q <= s_ctop ^ s_cout;
  end

  assign ovf = ovf_q;
`else
  logic unused_ctop;
  assign unused_ctop = s_ctop;
  assign ovf         = 1'b0;
`endif

  assign r    = r_q;
  assign cout = carry;
  assign eq   = eq_q;
  assign zero = zero_q;

endmodule
